// File: rtl/add_arb_pkg.sv
// Shared types and default sizing for the add_arbiter slice.
//   state_t   : controller states (IDLE, EXEC, RESP)
//   NREQ_DEF  : default number of requesters
//   WIDTH_DEF : default operand width
package add_arb_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_arb_pick.sv
// Winner select: scans the request vector starting at 'start', wrapping
// from NREQ-1 back to 0, and returns the first requester found.
//   req   : request vector
//   start : index where the search begins (tie 0 for fixed priority)
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner (0 when no request)
module add_arb_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  start,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    // Rotating priority search; first hit wins.
    always_comb begin
        logic        found;
        int unsigned pos;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = (32'(start) + k) % NREQ;
            if (!found && req[IDW'(pos)]) begin
                found             = 1'b1;
                grant[IDW'(pos)]  = 1'b1;
                idx               = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Shared adder arbitrated among NREQ requesters. One operation in flight:
// grant in IDLE, add in EXEC, hold the result in RESP until consumed.
// Compile-time option: ADD_ARB_RR_EN selects round-robin arbitration;
// without it the lowest requesting index always wins.
//   clk, rst_n        : clock, async active-low reset
//   req_valid/a/b     : per-requester request and operands (packed by index)
//   req_ready         : one-hot accept strobe, combinational in IDLE
//   rsp_valid/sum/id  : result, its owner, held until rsp_ready
//   rsp_ready         : consumer accept
//   busy              : controller not in IDLE
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [WIDTH:0]           rsp_sum,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned SW  = WIDTH + 1;

    state_t            state;
    state_t            state_nxt;
    logic              take;
    logic [NREQ-1:0]   pick_grant;
    logic [IDW-1:0]    pick_idx;
    logic [IDW-1:0]    pick_start;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    add_arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .start (pick_start),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

`ifdef ADD_ARB_RR_EN
    logic [IDW-1:0] rr_ptr;

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
        end
    end

    assign pick_start = rr_ptr;
`else
    assign pick_start = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is gated so it stays low in reset.
    always_comb begin
        take      = (state == IDLE) && (|req_valid);
        req_ready = (take && rst_n) ? pick_grant : '0;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Operand mux for the winning requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Capture on grant, add in EXEC; result is untouched while in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
        end else begin
            if (take) begin
                a_q    <= a_sel;
                b_q    <= b_sel;
                rsp_id <= pick_idx;
            end
            if (state == EXEC) begin
                rsp_sum <= SW'(a_q) + SW'(b_q);
            end
        end
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder (2..8).
REQ-002 Parameter WIDTH, default 4: operand width; result width is WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  NREQ x WIDTH  operand a per requester.
REQ-007 req_b  input  NREQ x WIDTH  operand b per requester.
REQ-008 req_ready  output  NREQ  one-hot accept strobe; at most one bit high per cycle.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_sum  output  WIDTH+1  a+b of the granted request.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_sum.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, EXEC and RESP SHALL be held in a single state register.
REQ-015 IDLE: if any req_valid is high, pick the winner, assert req_ready[winner] combinationally in that cycle, capture a, b and id, then go to EXEC; otherwise stay in IDLE.
REQ-016 EXEC: register rsp_sum = zero-extended a + zero-extended b (full WIDTH+1 bits, no truncation or saturation), then go to RESP.
REQ-017 RESP: rsp_valid high; rsp_sum and rsp_id SHALL stay stable until rsp_valid && rsp_ready; then go to IDLE.
REQ-018 Latency: rsp_valid rises exactly 2 cycles after the req_ready cycle; minimum throughput is one operation every 3 cycles.
REQ-019 req_ready SHALL be low in EXEC and RESP; requests are never accepted while a result is pending.
REQ-020 A requester SHALL hold req_valid and its operands stable until req_ready; the block makes no promise for a request withdrawn before its grant.
REQ-021 rsp_ready high outside RESP SHALL be ignored.
REQ-022 Arbitration when requesters collide in IDLE SHALL follow REQ-029/REQ-030.

Reset
REQ-023 While rst_n is low: state is IDLE; req_ready, rsp_valid, rsp_sum, rsp_id and busy are 0; the RR pointer is 0.
REQ-024 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced after release.
REQ-025 The first grant is possible on the first posedge after rst_n deasserts.

Configuration
REQ-026 Macro ADD_ARB_RR_EN selects the arbitration policy at compile time.
REQ-027 With the macro defined, a round-robin pointer exists and ports are unchanged.
REQ-028 Without the macro, no pointer flops exist and ports are unchanged.
REQ-029 ADD_ARB_RR_EN defined: round-robin; the search starts at the pointer and wraps NREQ-1 to 0; on each grant the pointer becomes (winner+1) mod NREQ.
REQ-030 ADD_ARB_RR_EN undefined: fixed priority; the lowest index wins.

Structure
REQ-031 Package add_arb_pkg SHALL hold the state enum (IDLE, EXEC, RESP) and the default NREQ/WIDTH localparams.
REQ-032 The winner-select logic SHALL be the sub-module add_arb_pick: inputs are the request vector and start pointer; outputs are the one-hot grant and the index.

Verification
REQ-033 Scenario: only req_valid[0] high, a=4, b=3 -> req_ready[0] pulses once; two cycles later rsp_valid=1, rsp_sum=7, rsp_id=0.
REQ-034 Scenario: all four requesters valid continuously, rsp_ready=1 -> with ADD_ARB_RR_EN the grant order is 0,1,2,3,0; without it every grant goes to 0.
REQ-035 Scenario: a=15, b=15 -> rsp_sum=30 (5'b11110); a=0, b=9 -> 9; a=7, b=9 -> 16.
REQ-036 Scenario: rsp_ready held low 5 cycles in RESP while req_valid[1] is high -> rsp_sum/rsp_id stable, req_ready all 0, busy=1; rsp_ready=1 -> IDLE, then requester 1 is granted.
REQ-037 Scenario: rst_n pulsed low during EXEC -> rsp_valid=0, busy=0, and the next grant goes to requester 0.
REQ-038 Scenario: 200 random ops with operands from $urandom_range(0,10) on random requesters -> every rsp_sum matches a+b of the matching rsp_id; no request is lost or duplicated; at most one req_ready bit is high per cycle.
